// File: rtl/lfsr_checker.sv
// lfsr_checker
// Checks a read-back byte stream against an 8-bit maximal-length (period 256)
// pseudo-random sequence seeded at 0xFF. Two modes are supported:
//   - seeded mode (SELF_SYNC=0): the expected sequence starts at 0xFF on start.
//   - self-sync mode (SELF_SYNC=1): the first accepted byte seeds the generator,
//     and LOSS_THRESH consecutive mismatches drop lock and re-synchronise.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   i_start        pulse: latch i_len, clear counters, begin a run
//   i_clear        pulse: clear counters, return to idle (wins over i_start)
//   i_len          number of bytes in the run
//   i_din          read-back data byte
//   i_din_valid    i_din is valid
//   o_din_ready    checker accepts a byte this cycle
//   o_busy         run in progress (sync or check)
//   o_done         run complete
//   o_locked       expected generator aligned to the input
//   o_err_pulse    one cycle per mismatching accepted byte
//   o_lost_pulse   one cycle on loss of lock
//   o_byte_cnt     accepted bytes in the current run
//   o_err_cnt      mismatching bytes, saturating
//   o_bit_err_cnt  total mismatching bits, saturating
module lfsr_checker #(
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned SELF_SYNC   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_clear,
    input  logic [31:0] i_len,
    input  logic [7:0]  i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_locked,
    output logic        o_err_pulse,
    output logic        o_lost_pulse,
    output logic [31:0] o_byte_cnt,
    output logic [15:0] o_err_cnt,
    output logic [23:0] o_bit_err_cnt
);

    typedef enum logic [1:0] {StIdle, StSync, StCheck, StDone} state_t;

    state_t      r_state;
    logic [7:0]  r_exp;
    logic [31:0] r_len;
    logic [31:0] r_byte_cnt;
    logic [15:0] r_err_cnt;
    logic [23:0] r_bit_err_cnt;
    logic [7:0]  r_run_cnt;
    logic        r_locked;
    logic        r_err_pulse;
    logic        r_lost_pulse;

    // One step of the sequence; the all-zero-tail term splices 0x00 into the
    // cycle so the period is the full 256.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        logic f;
        f = q[7] ^ (q[6:0] == 7'd0);
        return {q[6], q[5] ^ f, q[4] ^ f, q[3] ^ f, q[2], q[1], q[0], f};
    endfunction

    logic        w_busy;
    logic        w_accept;
    logic        w_mismatch;
    logic [3:0]  w_bit_errs;
    logic [7:0]  w_diff;
    logic [31:0] w_byte_cnt_nxt;
    logic        w_last;
    logic [15:0] w_err_cnt_nxt;
    logic [24:0] w_bit_sum;
    logic [23:0] w_bit_err_nxt;
    logic [7:0]  w_run_nxt;
    logic        w_lose;

    assign w_busy         = (r_state == StSync) || (r_state == StCheck);
    assign w_accept       = i_din_valid && w_busy;
    assign w_diff         = i_din ^ r_exp;
    assign w_mismatch     = (w_diff != 8'd0);
    assign w_byte_cnt_nxt = r_byte_cnt + 32'd1;
    assign w_last         = (w_byte_cnt_nxt == r_len);
    assign w_err_cnt_nxt  = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
    assign w_bit_sum      = {1'b0, r_bit_err_cnt} + {21'd0, w_bit_errs};
    assign w_bit_err_nxt  = w_bit_sum[24] ? 24'hFFFFFF : w_bit_sum[23:0];
    assign w_run_nxt      = r_run_cnt + 8'd1;
    assign w_lose         = (SELF_SYNC != 0) && (32'(w_run_nxt) == LOSS_THRESH);

    always_comb begin
        w_bit_errs = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_bit_errs = w_bit_errs + {3'd0, w_diff[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StIdle;
            r_exp         <= 8'hFF;
            r_len         <= 32'd0;
            r_byte_cnt    <= 32'd0;
            r_err_cnt     <= 16'd0;
            r_bit_err_cnt <= 24'd0;
            r_run_cnt     <= 8'd0;
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_lost_pulse  <= 1'b0;
        end else begin
            r_err_pulse  <= 1'b0;
            r_lost_pulse <= 1'b0;
            if (i_clear) begin
                r_state       <= StIdle;
                r_byte_cnt    <= 32'd0;
                r_err_cnt     <= 16'd0;
                r_bit_err_cnt <= 24'd0;
                r_run_cnt     <= 8'd0;
                r_locked      <= 1'b0;
            end else if (i_start) begin
                r_len         <= i_len;
                r_byte_cnt    <= 32'd0;
                r_err_cnt     <= 16'd0;
                r_bit_err_cnt <= 24'd0;
                r_run_cnt     <= 8'd0;
                if (i_len == 32'd0) begin
                    r_state  <= StDone;
                    r_locked <= 1'b0;
                end else if (SELF_SYNC == 0) begin
                    r_state  <= StCheck;
                    r_exp    <= 8'hFF;
                    r_locked <= 1'b1;
                end else begin
                    r_state  <= StSync;
                    r_locked <= 1'b0;
                end
            end else if (w_accept) begin
                r_byte_cnt <= w_byte_cnt_nxt;
                if (r_state == StSync) begin
                    // The received byte becomes the current sequence value.
                    r_exp     <= lfsr_next(i_din);
                    r_locked  <= 1'b1;
                    r_run_cnt <= 8'd0;
                end else begin
                    r_exp <= lfsr_next(r_exp);
                    if (w_mismatch) begin
                        r_err_pulse   <= 1'b1;
                        r_err_cnt     <= w_err_cnt_nxt;
                        r_bit_err_cnt <= w_bit_err_nxt;
                        if (w_lose) begin
                            r_lost_pulse <= 1'b1;
                            r_locked     <= 1'b0;
                            r_run_cnt    <= 8'd0;
                        end else begin
                            r_run_cnt <= w_run_nxt;
                        end
                    end else begin
                        r_run_cnt <= 8'd0;
                    end
                end
                // Completing the run outranks a re-sync.
                if (w_last) begin
                    r_state <= StDone;
                end else if (r_state == StSync) begin
                    r_state <= StCheck;
                end else if (w_mismatch && w_lose) begin
                    r_state <= StSync;
                end
            end
        end
    end

    assign o_busy        = w_busy;
    assign o_din_ready   = w_busy;
    assign o_done        = (r_state == StDone);
    assign o_locked      = r_locked;
    assign o_err_pulse   = r_err_pulse;
    assign o_lost_pulse  = r_lost_pulse;
    assign o_byte_cnt    = r_byte_cnt;
    assign o_err_cnt     = r_err_cnt;
    assign o_bit_err_cnt = r_bit_err_cnt;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOSS_THRESH, default 8: the number of consecutive mismatching bytes that causes loss of lock in self-sync mode (legal range 1..255).
REQ-002 Parameter SELF_SYNC, default 0: 0 selects seeded mode, 1 selects self-synchronising mode.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; latches len and begins a check run.
REQ-006 clear  input  1  single-cycle pulse; zeroes all counters and returns to IDLE.
REQ-007 len  input  32  number of bytes to check in the run.
REQ-008 din  input  8  read-back data byte.
REQ-009 din_valid  input  1  din is valid; a byte is accepted when din_valid=1 and din_ready=1.
REQ-010 din_ready  output  1  checker can accept a byte.
REQ-011 busy  output  1  a run is in progress.
REQ-012 done  output  1  the run has completed.
REQ-013 locked  output  1  the expected-sequence generator is aligned to the input.
REQ-014 err_pulse  output  1  one cycle high for each mismatching accepted byte.
REQ-015 lost_pulse  output  1  one cycle high on loss of lock.
REQ-016 byte_cnt  output  32  accepted bytes in the current run.
REQ-017 err_cnt  output  16  mismatching bytes; saturates at 0xFFFF.
REQ-018 bit_err_cnt  output  24  sum of popcount(din XOR expected); saturates at 0xFFFFFF.

Function
REQ-019 Sequence definition, with f = q[7] XOR (q[6:0]==0): next q = {q[6], q[5]^f, q[4]^f, q[3]^f, q[2], q[1], q[0], f}; period 256; seed 0xFF. The first three values are FF, 8F, 6F.
REQ-020 States are IDLE, SYNC, CHECK and DONE; busy=1 in SYNC and CHECK; din_ready=busy; done=1 only in DONE.
REQ-021 start in any state:
- clears byte_cnt, err_cnt, bit_err_cnt and the mismatch run counter;
- latches len;
- if len=0, enters DONE the next cycle;
- else if SELF_SYNC=0, enters CHECK with expected=0xFF and locked=1;
- else enters SYNC with locked=0.
REQ-022 SYNC, on an accepted byte b:
- no comparison is made and no error is counted;
- expected is set to next(b);
- byte_cnt increments;
- locked=1 and the state moves to CHECK (or to DONE if byte_cnt reaches len).
REQ-023 CHECK, on an accepted byte:
- compare din with expected, then advance expected one step;
- byte_cnt increments;
- on mismatch: err_pulse=1 the following cycle, err_cnt increments by 1, bit_err_cnt increments by the popcount, and the run counter increments;
- on match: the run counter clears.
REQ-024 Results are registered: counters and pulses reflect an accepted byte in the cycle after acceptance (latency 1).
REQ-025 If SELF_SYNC=1 and the run counter reaches LOSS_THRESH:
- lost_pulse=1;
- locked=0;
- run counter clears;
- state moves to SYNC.
byte_cnt continues counting. With SELF_SYNC=0, lock is never lost.
REQ-026 When the accepted byte makes byte_cnt equal len, the state moves to DONE after that byte has been checked and counted. Counters then hold until the next start or clear.
REQ-027 In IDLE and DONE, din_valid is ignored and no counter changes.
REQ-028 If clear and start are asserted in the same cycle, clear wins: counters are zeroed, the state is IDLE and locked=0.
REQ-029 If start is asserted during SYNC or CHECK, the run aborts and restarts per REQ-021. No partial result is retained.
REQ-030 Saturated counters hold their maximum value. err_pulse and lost_pulse still fire after saturation.

Reset
REQ-031 While rst=0, the following hold regardless of clk: state=IDLE, expected=0xFF, all counters=0, and busy, done, locked, err_pulse, lost_pulse and din_ready all =0.
REQ-032 Reset asserted mid-run aborts the run. After release the block is in IDLE and waits for start.

Verification
REQ-033 SELF_SYNC=0, len=3, din=FF,8F,6F each valid -> err_cnt=0, bit_err_cnt=0, byte_cnt=3, done=1.
REQ-034 SELF_SYNC=0, len=3, din=FF,8E,6F -> a single err_pulse one cycle after 8E is accepted, err_cnt=1, bit_err_cnt=1.
REQ-035 SELF_SYNC=1, len=3, din=8F,6F,(next value) -> locked=1 after the first byte, err_cnt=0, byte_cnt=3.
REQ-036 SELF_SYNC=1, LOSS_THRESH=2, locked, two consecutive wrong bytes -> lost_pulse, locked=0, state SYNC; the next valid byte re-locks.
REQ-037 start with len=0 -> done=1 the next cycle, byte_cnt=0; start asserted together with clear -> IDLE with counters 0.
REQ-038 rst pulled low mid-run at byte_cnt=5 -> all outputs 0 immediately (asynchronously); din_ready=0 until the next start.
